// File: rtl/mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// mux_nto1_reg
//
// Registered N-to-1 channel multiplexer with an optional automatic scan mode.
// In manual mode the channel picked by S is registered onto Y. In scan mode the
// block walks channels 0..N-1, presenting each one for DWELL cycles. SOF marks
// the first dwell cycle of channel 0, which is the start of each scan frame.
//
// Build option:
//   MUX_NTO1_SCAN_EN  - defined  : scan mode, ptr/cnt state and SOF are built.
//                       undefined: M is ignored, the block is always in manual
//                                  mode and SOF is tied to 0. Ports are unchanged.
//
// Parameters:
//   N      number of input channels (2..16)
//   W      width of one channel in bits (1..32)
//   DWELL  cycles each channel is shown in scan mode (1..255)
//   SW     select/channel field width, max(1, ceil(log2 N)) (derived)
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   synchronous active-high reset
//   I    in   packed channels; channel k is I[k*W +: W]
//   S    in   manual channel select
//   M    in   mode: 0 = manual, 1 = scan
//   EN   in   advance enable; 0 freezes Y/CH and scan position
//   Y    out  registered selected data
//   CH   out  index of the channel currently on Y
//   V    out  Y/CH were updated at the last edge
//   SOF  out  start of scan frame
// -----------------------------------------------------------------------------
module mux_nto1_reg #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 1,
  localparam int SW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] I,
  input  logic [SW-1:0]  S,
  input  logic           M,
  input  logic           EN,
  output logic [W-1:0]   Y,
  output logic [SW-1:0]  CH,
  output logic           V,
  output logic           SOF
);

  // Manual-path selection. When N is not a power of two, S can address a
  // channel that does not exist; man_ok flags that so the outputs can hold.
  logic [W-1:0] man_data;
  logic         man_ok;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    man_data = '0;
    man_ok   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'(S) == k) begin
        man_data = I[k*W +: W];
        man_ok   = 1'b1;
      end
    end
  end

`ifdef MUX_NTO1_SCAN_EN

  localparam logic [7:0]    CNT_LAST = 8'(DWELL - 1);
  localparam logic [SW-1:0] PTR_LAST = SW'(N - 1);

  // Scan position: ptr is the channel being presented, cnt counts dwell
  // cycles on it. Both sit at 0 whenever the block is not scanning, which is
  // what makes a manual->scan switch start cleanly at channel 0 with SOF.
  logic [SW-1:0] ptr;
  logic [7:0]    cnt;
  logic [W-1:0]  scan_data;
  logic          sof_q;

  always_comb begin
    scan_data = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(ptr) == k) begin
        scan_data = I[k*W +: W];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the values from before the edge, regardless of the
  // order of statements inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y     <= '0;
      CH    <= '0;
      V     <= 1'b0;
      sof_q <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (!EN) begin
      // Frozen: data, channel and scan position hold; only the strobes drop.
      V     <= 1'b0;
      sof_q <= 1'b0;
    end else if (M) begin
      Y     <= scan_data;
      CH    <= ptr;
      V     <= 1'b1;
      sof_q <= (ptr == '0) && (cnt == '0);
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      // Manual mode abandons any scan in progress.
      ptr   <= '0;
      cnt   <= '0;
      sof_q <= 1'b0;
      if (man_ok) begin
        Y  <= man_data;
        CH <= S;
        V  <= 1'b1;
      end else begin
        V  <= 1'b0;
      end
    end
  end

  assign SOF = sof_q;

`else

  // Scan support is not built: the mode input has no effect.
  logic unused_m;
  assign unused_m = M;

  always_ff @(posedge clk) begin
    if (rst) begin
      Y  <= '0;
      CH <= '0;
      V  <= 1'b0;
    end else if (!EN) begin
      V  <= 1'b0;
    end else if (man_ok) begin
      Y  <= man_data;
      CH <= S;
      V  <= 1'b1;
    end else begin
      V  <= 1'b0;
    end
  end

  assign SOF = 1'b0;

`endif

endmodule

// File: tb/tb_mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_reg
//
// Drives two instances of mux_nto1_reg from the same stimulus:
//   dut4 : N=4, W=8, DWELL=2 (power-of-two channel count)
//   dut3 : N=3, W=8, DWELL=3 (select can be out of range, non-binary wrap)
// A reference model predicts each edge's outputs and queues them; monitors
// pop and compare after every rising edge. The model tracks scan progress as
// a plain step count since the scan started, from which channel and SOF are
// derived arithmetically.
// -----------------------------------------------------------------------------
module tb_mux_nto1_reg;

`ifdef MUX_NTO1_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_in = '0;
  logic [1:0]  s_in = '0;
  logic        m_in = 1'b0;
  logic        en_in = 1'b0;

  logic [7:0] y4, y3;
  logic [1:0] ch4, ch3;
  logic       v4, v3, sof4, sof3;

  always #5 clk = ~clk;

  mux_nto1_reg #(.N(4), .W(8), .DWELL(2)) dut4 (
    .clk (clk), .rst (rst), .I (i_in), .S (s_in), .M (m_in), .EN (en_in),
    .Y (y4), .CH (ch4), .V (v4), .SOF (sof4)
  );

  mux_nto1_reg #(.N(3), .W(8), .DWELL(3)) dut3 (
    .clk (clk), .rst (rst), .I (i_in[23:0]), .S (s_in), .M (m_in), .EN (en_in),
    .Y (y3), .CH (ch3), .V (v3), .SOF (sof3)
  );

  typedef struct {
    logic [7:0] y;
    logic [1:0] ch;
    logic       v;
    logic       sof;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model state, one slot per DUT (0 = dut4, 1 = dut3).
  // ---------------------------------------------------------------------------
  int         m_n[2]  = '{4, 3};
  int         m_dw[2] = '{2, 3};
  logic [7:0] m_y[2];
  int         m_ch[2];
  bit         m_v[2];
  bit         m_sof[2];
  int         m_step[2];

  task automatic model(input int d, input bit r, input bit en, input bit m,
                       input int s, input logic [31:0] i);
    int          n  = m_n[d];
    int          dw = m_dw[d];
    int          c;
    exp_t        e;
    logic [31:0] iv;
    iv = (n == 3) ? (i & 32'h00FF_FFFF) : i;
    if (r) begin
      m_y[d] = '0; m_ch[d] = 0; m_v[d] = 0; m_sof[d] = 0; m_step[d] = 0;
    end else if (!en) begin
      m_v[d] = 0; m_sof[d] = 0;
    end else if (m && SCAN) begin
      c         = (m_step[d] / dw) % n;
      m_y[d]    = 8'(iv >> (8 * c));
      m_ch[d]   = c;
      m_v[d]    = 1;
      m_sof[d]  = (m_step[d] % (dw * n)) == 0;
      m_step[d] = m_step[d] + 1;
    end else begin
      m_step[d] = 0;
      m_sof[d]  = 0;
      if (s < n) begin
        m_y[d]  = 8'(iv >> (8 * s));
        m_ch[d] = s;
        m_v[d]  = 1;
      end else begin
        m_v[d]  = 0;
      end
    end
    e.y = m_y[d]; e.ch = 2'(m_ch[d]); e.v = m_v[d]; e.sof = m_sof[d];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One clock of stimulus: inputs change on the falling edge, the model
  // predicts what the following rising edge will register.
  task automatic cyc(input bit r, input bit en, input bit m, input logic [1:0] s,
                     input logic [31:0] i);
    @(negedge clk);
    rst = r; en_in = en; m_in = m; s_in = s; i_in = i;
    model(0, r, en, m, int'(s), i);
    model(1, r, en, m, int'(s), i);
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: compare one queued expectation per rising edge.
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    #1;
    if (q0.size() != 0) begin
      e0 = q0.pop_front();
      check("dut4_y",   32'(y4),   32'(e0.y));
      check("dut4_ch",  32'(ch4),  32'(e0.ch));
      check("dut4_v",   32'(v4),   32'(e0.v));
      check("dut4_sof", 32'(sof4), 32'(e0.sof));
    end
  end

  always @(posedge clk) begin
    #1;
    if (q1.size() != 0) begin
      e1 = q1.pop_front();
      check("dut3_y",   32'(y3),   32'(e1.y));
      check("dut3_ch",  32'(ch3),  32'(e1.ch));
      check("dut3_v",   32'(v3),   32'(e1.v));
      check("dut3_sof", 32'(sof3), 32'(e1.sof));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected done", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] I0 = 32'h4433_2211;

  initial begin
    logic        r, en, m;
    logic [1:0]  s;
    logic [31:0] i;

    // Reset held for two edges with scan requested.
    repeat (2) cyc(1, 1, 1, 2'd0, I0);
    // Manual select of channel 2.
    cyc(0, 1, 0, 2'd2, I0);
    // Scan with wrap, S ignored.
    for (int k = 0; k < 10; k++) cyc(0, 1, 1, 2'(k), I0);
    // Continue into the middle of a dwell, then freeze while I changes.
    repeat (3) cyc(0, 1, 1, 2'd0, I0);
    cyc(0, 0, 1, 2'd3, 32'hDEAD_BEEF);
    cyc(0, 0, 0, 2'd1, 32'h0BAD_F00D);
    cyc(0, 0, 1, 2'd2, 32'h1234_5678);
    repeat (3) cyc(0, 1, 1, 2'd0, 32'h1234_5678);
    // Mode switch mid-scan, return to scan, then reset mid-dwell.
    cyc(1, 1, 1, 2'd0, I0);
    repeat (7) cyc(0, 1, 1, 2'd0, I0);
    cyc(0, 1, 0, 2'd1, I0);
    repeat (5) cyc(0, 1, 1, 2'd3, I0);
    cyc(1, 1, 1, 2'd0, I0);
    repeat (4) cyc(0, 1, 1, 2'd0, I0);
    // Manual select at the top of the field: out of range for three channels.
    cyc(0, 1, 0, 2'd1, 32'hA1B2_C3D4);
    cyc(0, 1, 0, 2'd3, 32'h5566_7788);
    cyc(0, 1, 0, 2'd3, 32'h99AA_BBCC);
    cyc(0, 1, 0, 2'd0, 32'h99AA_BBCC);

    // Randomised traffic; mode changes in runs so scans make progress.
    m = 1'b1;
    for (int k = 0; k < 500; k++) begin
      r  = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 11) == 0) m = ~m;
      s  = 2'($urandom_range(0, 3));
      i  = $urandom;
      cyc(r, en, m, s, i);
    end

    repeat (3) @(negedge clk);
    check("dut4_queue_drained", 32'(q0.size()), 32'd0);
    check("dut3_queue_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
